addsub_pipe_nbit: RTL and testbench
===================================

// Module: addsub_pipe_nbit
// PURPOSE
//   Parametrised, pipelined add/subtract unit for the datapath ALU.
//   - Next generation of the 8-bit ripple adder; the operand width is generic.
//   - Carry is chained across STAGES register slices, so wide operands meet timing.
//   - Valid/ready handshake with backpressure, so the ALU control FSM can stall it.
//   - Produces carry, signed overflow, negative and zero flags.
// PARAMETERS
//   WIDTH   8  operand/result width in bits; must be a multiple of STAGES
//   STAGES  1  pipeline depth; each stage adds one WIDTH/STAGES-bit slice (1..WIDTH)
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operand bundle valid
//   in_ready   out  1      unit can accept a bundle this cycle
//   x          in   WIDTH  operand A
//   y          in   WIDTH  operand B
//   c_in       in   1      add: carry-in; sub: borrow-in
//   op_sub     in   1      0 = x+y+c_in, 1 = x-y-c_in
//   out_valid  out  1      result bundle valid
//   out_ready  in   1      downstream accepts the result
//   o          out  WIDTH  result
//   cout       out  1      carry-out; for sub, 1 = no borrow
//   ovf        out  1      signed two's-complement overflow
//   neg        out  1      o[WIDTH-1]
//   zero       out  1      o == 0
// BEHAVIOUR
//   - Reset (async assert, sync release): all stage valid bits, out_valid, o,
//     cout, ovf, neg and zero go to 0. in_ready = 1 once rst_n = 1.
//   - Transfer: in on in_valid&in_ready; out on out_valid&out_ready.
//   - Global advance: adv = !out_valid | out_ready. Every stage (valid bit and
//     data) loads only when adv = 1. in_ready = adv, combinational from out_ready.
//   - Latency: exactly STAGES cycles from acceptance to out_valid with no stall.
//     Throughput is 1 bundle/cycle. Results leave in acceptance order.
//   - Sub: effective yb = ~y, cin0 = ~c_in. Add: yb = y, cin0 = c_in.
//   - Stage k (k = 0..STAGES-1) adds slice k of x and yb, plus the carry
//     registered by stage k-1 (cin0 for k = 0).
//     - Upper, unprocessed slices are carried forward unchanged.
//     - Lower result slices are carried forward unchanged.
//   - Flags are computed in the final stage from the full result:
//     - ovf = (x[MSB] == yb[MSB]) & (o[MSB] != x[MSB])
//     - cout = carry out of the MSB slice
//   - Bubble: if in_valid = 0 while adv = 1, a bubble enters the pipeline
//     (stage valid = 0). Bubbles collapse only at the output.
//   - Stall: while out_valid & !out_ready, o and all flags hold stable and
//     no stage moves.
//   - Reset mid-operation: every in-flight bundle is discarded. Nothing emerges
//     after release.
//   - Wrap: without saturation, the result is modulo 2^WIDTH.
// CONFIGURATION
//   ADDSUB_SAT_EN defined:
//     - Adds input port `sat` (1 bit), sampled with the operands and piped alongside.
//     - When sat = 1 and ovf = 1, o = 0x7F..F (positive overflow) or 0x80..0
//       (negative overflow). ovf still reports 1; cout is unmodified.
//     - zero and neg are taken from the saturated o.
//   ADDSUB_SAT_EN undefined:
//     - The `sat` port does not exist. The result always wraps.
// TESTING
//   1 W=8,S=1: x=FF y=01 c_in=0 add -> 1 cycle later o=00 cout=1 zero=1 ovf=0
//   2 W=16,S=4: 4 back-to-back bundles incl 0FFF+0001, out_ready=1 -> outputs at
//     cycles 4..7 in order; 0FFF+0001 gives 1000 (carry crosses slices), cout=0
//   3 W=8 sub: 05-07 -> o=FE cout=0 ovf=0 neg=1; 80-01 -> o=7F ovf=1; 10-10 c_in=1 -> FF
//   4 W=8,S=2: full pipe, out_ready=0 for 3 cycles -> in_ready=0, o/flags stable;
//     no bundle lost or duplicated after release
//   5 W=8,S=4: rst_n low 1 cycle with 2 bundles in flight -> out_valid=0 at once;
//     no output for 4 cycles after release
//   6 ADDSUB_SAT_EN, sat=1: 7F+01 -> o=7F ovf=1; 80-01 -> o=80 ovf=1;
//     sat=0 7F+01 -> o=80

Source files
------------

// File: rtl/addsub_pipe_nbit.sv
// addsub_pipe_nbit
//   Pipelined WIDTH-bit add/subtract unit. The carry chain is split into
//   STAGES slices of WIDTH/STAGES bits. Each register stage resolves one slice
//   and hands its carry to the next stage. The final stage also registers the
//   result and the carry/overflow/negative/zero flags. A valid/ready handshake
//   lets downstream logic stall the whole pipeline.
//   Constraint: WIDTH must be a multiple of STAGES, with 1 <= STAGES <= WIDTH.
//
//   Optional feature: define ADDSUB_SAT_EN to add the `sat` input. When sat is
//   set and the result overflows, o saturates to the most-positive or
//   most-negative value.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand bundle handshake (x, y, c_in, op_sub[, sat])
//   x, y                 operands
//   c_in                 carry-in (add) or borrow-in (sub)
//   op_sub               0: x+y+c_in   1: x-y-c_in
//   out_valid/out_ready  result bundle handshake
//   o                    result
//   cout                 carry-out (sub: 1 = no borrow)
//   ovf                  signed overflow
//   neg                  o[WIDTH-1]
//   zero                 o == 0
module addsub_pipe_nbit #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  input  logic             op_sub,
`ifdef ADDSUB_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic             cout,
  output logic             ovf,
  output logic             neg,
  output logic             zero
);

  localparam int unsigned SW = WIDTH / STAGES;

  logic              adv;
  logic [STAGES-1:0] v_q;

  // Stage-k inputs: ports for k = 0, otherwise the registers of stage k-1.
  logic [WIDTH-1:0] x_i  [STAGES];
  logic [WIDTH-1:0] yb_i [STAGES];
  logic [WIDTH-1:0] r_i  [STAGES];
  logic             c_i  [STAGES];
  logic             s_i  [STAGES];

  // Stage-k combinational results.
  logic [WIDTH-1:0] r_d  [STAGES];
  logic             c_d  [STAGES];

  logic [SW:0]      sum;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] o_d;
  logic             ovf_d;
  logic             msb_x;
  logic             msb_y;
  logic             sat_in;

`ifdef ADDSUB_SAT_EN
  assign sat_in = sat;
`else
  assign sat_in = 1'b0;
`endif

  assign out_valid = v_q[STAGES-1];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  // Subtraction is x + ~y + ~borrow.
  assign x_i[0]  = x;
  assign yb_i[0] = op_sub ? ~y : y;
  assign c_i[0]  = c_in ^ op_sub;
  assign r_i[0]  = '0;
  assign s_i[0]  = sat_in;

  always_comb begin
    sum = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      sum = {1'b0, x_i[k][k*SW +: SW]} + {1'b0, yb_i[k][k*SW +: SW]}
          + {{SW{1'b0}}, c_i[k]};
      r_d[k]             = r_i[k];
      r_d[k][k*SW +: SW] = sum[SW-1:0];
      c_d[k]             = sum[SW];
    end

    res   = r_d[STAGES-1];
    msb_x = x_i[STAGES-1][WIDTH-1];
    msb_y = yb_i[STAGES-1][WIDTH-1];
    ovf_d = (msb_x == msb_y) && (res[WIDTH-1] != msb_x);
    o_d   = res;
    // The operand sign gives the overflow direction: both operands negative
    // means the result underflowed.
    if (s_i[STAGES-1] && ovf_d) begin
      o_d = msb_x ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  // Intermediate slice registers exist only when there is more than one stage.
  if (STAGES > 1) begin : g_pipe
    logic [WIDTH-1:0] x_q  [STAGES-1];
    logic [WIDTH-1:0] yb_q [STAGES-1];
    logic [WIDTH-1:0] r_q  [STAGES-1];
    logic             c_q  [STAGES-1];
    logic             s_q  [STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned k = 0; k < STAGES - 1; k++) begin
          x_q[k]  <= '0;
          yb_q[k] <= '0;
          r_q[k]  <= '0;
          c_q[k]  <= 1'b0;
          s_q[k]  <= 1'b0;
        end
      end else if (adv) begin
        for (int unsigned k = 0; k < STAGES - 1; k++) begin
          x_q[k]  <= x_i[k];
          yb_q[k] <= yb_i[k];
          r_q[k]  <= r_d[k];
          c_q[k]  <= c_d[k];
          s_q[k]  <= s_i[k];
        end
      end
    end

    for (genvar k = 1; k < STAGES; k++) begin : g_link
      assign x_i[k]  = x_q[k-1];
      assign yb_i[k] = yb_q[k-1];
      assign r_i[k]  = r_q[k-1];
      assign c_i[k]  = c_q[k-1];
      assign s_i[k]  = s_q[k-1];
    end
  end

  // Valid chain and registered outputs (final stage).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q  <= '0;
      o    <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
      neg  <= 1'b0;
      zero <= 1'b0;
    end else if (adv) begin
      v_q[0] <= in_valid;
      for (int unsigned k = 1; k < STAGES; k++) begin
        v_q[k] <= v_q[k-1];
      end
      o    <= o_d;
      cout <= c_d[STAGES-1];
      ovf  <= ovf_d;
      neg  <= o_d[WIDTH-1];
      zero <= (o_d == '0);
    end
  end

endmodule

// File: tb/tb_addsub_pipe_nbit.sv
// Testbench for addsub_pipe_nbit (WIDTH=16, STAGES=4). Expected results come
// from a behavioural reference model, are queued when a bundle is accepted,
// and are popped when the DUT presents a result.
// Build with ADDSUB_SAT_EN defined to include the saturation scenarios.
module tb_addsub_pipe_nbit;
  localparam int unsigned W = 16;
  localparam int unsigned S = 4;

  typedef struct {
    logic [W-1:0] o;
    logic         cout;
    logic         ovf;
    logic         neg;
    logic         zero;
    int unsigned  cyc;
    bit           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         c_in = 1'b0;
  logic         op_sub = 1'b0;
  logic         sat_b = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] o;
  logic         cout, ovf, neg, zero;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc = 0;
  bit          lat_chk = 1'b0;
  string       cur_test = "init";
  exp_t        sb[$];
  exp_t        mon_e;

  addsub_pipe_nbit #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .c_in(c_in), .op_sub(op_sub),
`ifdef ADDSUB_SAT_EN
    .sat(sat_b),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .o(o), .cout(cout),
    .ovf(ovf), .neg(neg), .zero(zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic sub, input logic s);
    exp_t         e;
    logic [W-1:0] bb;
    logic [W:0]   full;
    bb     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ci ^ sub};
    e.o    = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (a[W-1] == bb[W-1]) && (e.o[W-1] != a[W-1]);
    if (s && e.ovf) e.o = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    e.neg  = e.o[W-1];
    e.zero = (e.o == '0);
    e.cyc  = 0;
    e.lat  = 1'b0;
    return e;
  endfunction

  // Scoreboard check on every output transfer.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL %s unexpected_output: got o=%h with no bundle outstanding", cur_test, o);
      end else begin
        mon_e = sb.pop_front();
        if ({o, cout, ovf, neg, zero} !== {mon_e.o, mon_e.cout, mon_e.ovf, mon_e.neg, mon_e.zero}) begin
          fails++;
          $display("FAIL %s result: got o=%h c=%b v=%b n=%b z=%b, expected o=%h c=%b v=%b n=%b z=%b",
                   cur_test, o, cout, ovf, neg, zero,
                   mon_e.o, mon_e.cout, mon_e.ovf, mon_e.neg, mon_e.zero);
        end
        if (mon_e.lat) begin
          tests++;
          if (cyc - mon_e.cyc !== S) begin
            fails++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", cur_test, cyc - mon_e.cyc, S);
          end
        end
      end
    end
  end

  // Present one bundle and hold it until accepted; queue its expected result.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ci, input logic sub, input logic s);
    exp_t        e;
    int unsigned guard = 0;
    in_valid = 1'b1; x = a; y = b; c_in = ci; op_sub = sub; sat_b = s;
    @(negedge clk);
    while (!in_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL %s accept_timeout: in_ready=%b, expected 1", cur_test, in_ready);
    end else begin
      e     = model(a, b, ci, sub, s);
      e.cyc = cyc;
      e.lat = lat_chk;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    repeat (S + 2) @(posedge clk);
    #1;
    tests++;
    if (sb.size() !== 0) begin
      fails++;
      $display("FAIL %s drain: %0d bundles outstanding, expected 0", cur_test, sb.size());
    end
  endtask

  task automatic test_reset();
    cur_test = "reset";
    #1;
    tests++;
    if ({out_valid, o, cout, ovf, neg, zero} !== '0) begin
      fails++;
      $display("FAIL reset outputs: got v=%b o=%h c=%b v=%b n=%b z=%b, expected all 0",
               out_valid, o, cout, ovf, neg, zero);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset release: got in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    cur_test = "add";
    out_ready = 1'b1;
    lat_chk = 1'b1;
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    drain();
    send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    drain();
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    drain();
    lat_chk = 1'b0;
  endtask

  task automatic test_back_to_back();
    cur_test = "back_to_back";
    out_ready = 1'b1;
    lat_chk = 1'b1;
    send(16'h0FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    send(16'h1234, 16'h4321, 1'b1, 1'b0, 1'b0);
    send(16'h00FF, 16'h0F01, 1'b0, 1'b0, 1'b0);
    send(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 1'b0);
    drain();
    lat_chk = 1'b0;
  endtask

  task automatic test_sub();
    cur_test = "sub";
    out_ready = 1'b1;
    send(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
    send(16'h0010, 16'h0010, 1'b1, 1'b1, 1'b0);
    send(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    send(16'h1000, 16'h0001, 1'b0, 1'b1, 1'b0);
    drain();
  endtask

  task automatic test_stall();
    cur_test = "stall";
    out_ready = 1'b0;
    for (int i = 0; i < S; i++) send(W'(16'h1111 * (i + 1)), 16'h0F0F, 1'b0, i[0], 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL stall handshake: got out_valid=%b in_ready=%b, expected 1 0", out_valid, in_ready);
      end
      tests++;
      if ({o, cout, ovf, neg, zero} !== {sb[0].o, sb[0].cout, sb[0].ovf, sb[0].neg, sb[0].zero}) begin
        fails++;
        $display("FAIL stall hold: got o=%h c=%b v=%b n=%b z=%b, expected o=%h c=%b v=%b n=%b z=%b",
                 o, cout, ovf, neg, zero, sb[0].o, sb[0].cout, sb[0].ovf, sb[0].neg, sb[0].zero);
      end
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_random();
    bit done = 1'b0;
    cur_test = "random";
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    drain();
  endtask

  task automatic test_reset_midflight();
    cur_test = "reset_midflight";
    out_ready = 1'b1;
    send(16'h0101, 16'h0202, 1'b0, 1'b0, 1'b0);
    send(16'h0303, 16'h0404, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    sb.delete();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_midflight assert: out_valid=%b, expected 0", out_valid);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < S + 2; i++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL reset_midflight drain: out_valid=%b at cycle %0d after release, expected 0", out_valid, i);
      end
    end
    @(posedge clk); #1;
  endtask

`ifdef ADDSUB_SAT_EN
  task automatic test_sat();
    cur_test = "sat";
    out_ready = 1'b1;
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    send(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1);
    send(16'h1234, 16'h0001, 1'b0, 1'b0, 1'b1);
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_sub();
    test_stall();
    test_random();
    test_reset_midflight();
`ifdef ADDSUB_SAT_EN
    test_sat();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
